dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU MEM stage (primary) and a DMA/loader port (secondary, e.g. UART bootloader or a peripheral copy engine).
- Sits between the MEM stage's RAM-side signals (peripheral addresses are already decoded out upstream) and the data memory. The memory has combinational read and writes on the clk rising edge.
- The CPU normally wins. A starvation counter forces a one-cycle DMA grant, during which the CPU is stalled.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive denied DMA cycles before a forced DMA grant. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access this cycle (MemRead|MemWrite, RAM-targeted)
- cpu_we  input  1  1=write, 0=read
- cpu_addr  input  ADDR_W  CPU byte address
- cpu_wdata  input  DATA_W  CPU store data
- cpu_rdata  output  DATA_W  CPU load data, combinational
- cpu_stall  output  1  CPU access not serviced this cycle; pipeline must hold EX/MEM
- dma_req  input  1  DMA request; held until dma_gnt
- dma_we  input  1  1=write, 0=read
- dma_addr  input  ADDR_W  DMA byte address
- dma_wdata  input  DATA_W  DMA write data
- dma_gnt  output  1  DMA access performed this cycle, combinational
- dma_rdata  output  DATA_W  registered DMA read data
- dma_rvalid  output  1  one-cycle pulse, dma_rdata valid
- mem_addr  output  ADDR_W  to RAM
- mem_wdata  output  DATA_W  to RAM
- mem_read  output  1  to RAM
- mem_write  output  1  to RAM
- mem_rdata  input  DATA_W  from RAM, combinational

Behaviour:
- Reset: already decided — reset rst_n, asynchronous, active-low; clock clk.
  - On reset: starve_cnt=0, dma_rdata=0, dma_rvalid=0, owner register=CPU.
  - Combinational outputs follow the rules below with the counter at 0.
  - A reset mid-access aborts it: no write is retried and no rvalid is issued afterwards.
- Grant decision, combinational each cycle:
  - force = dma_req && (starve_cnt == STARVE_LIMIT).
  - dma_gnt = dma_req && (!cpu_req || force).
  - cpu_gnt = cpu_req && !dma_gnt.
  - cpu_stall = cpu_req && dma_gnt.
- Memory mux:
  - When dma_gnt: mem_* driven from dma_*.
  - When cpu_gnt: mem_* driven from cpu_*.
  - mem_read = granted && !we; mem_write = granted && we.
  - When neither is granted: mem_read=mem_write=0, mem_addr/mem_wdata=0.
- cpu_rdata = mem_rdata when cpu_gnt && !cpu_we, else 0.
- Starvation counter, updated at posedge:
  - dma_req && !dma_gnt → increment, saturating at STARVE_LIMIT.
  - dma_gnt or !dma_req → 0.
- DMA read return:
  - On a DMA read grant, dma_rdata <= mem_rdata and dma_rvalid <= 1 next cycle, for exactly one cycle.
  - Otherwise dma_rvalid <= 0 and dma_rdata holds its value.
  - DMA writes never pulse rvalid.
- Owner register:
  - Records the last granted requester (CPU/DMA). Used only for debug/inspection; never affects grant.
- Timing:
  - CPU latency is 0 extra cycles when granted.
  - A stalled CPU access is serviced in the following cycle: force clears the counter and the CPU wins next cycle unless dma_req is present with counter==STARVE_LIMIT, which is impossible right after a clear when STARVE_LIMIT>=1.
  - Maximum CPU stall is 1 cycle per STARVE_LIMIT+1 cycles.
  - Maximum DMA wait under continuous cpu_req is STARVE_LIMIT cycles.
- Both requesters writing the same address in one cycle: only the granted write reaches RAM; the loser retries by protocol.
- No address checking: addresses pass through unmodified. Alignment and range are the requester's responsibility.

Test Plan:
- Reset released, idle requests → all mem_* 0, cpu_stall=0, dma_gnt=0, dma_rvalid=0, dma_rdata=0.
- CPU-only write addr 0x10 data 0xDEADBEEF, then read 0x10 → mem_write=1 in cycle 1; cpu_rdata=0xDEADBEEF combinationally in cycle 2; cpu_stall never asserted.
- DMA-only read of 0x20 (RAM holds 0x12345678), cpu_req=0 → dma_gnt=1 the same cycle; dma_rvalid=1 and dma_rdata=0x12345678 the next cycle only.
- cpu_req held 1 continuously, dma_req asserted at cycle 0, STARVE_LIMIT=4:
  - dma_gnt=0 in cycles 0–3; dma_gnt=1 and cpu_stall=1 in cycle 4; counter returns to 0.
  - CPU serviced in cycle 5 with no RAM write duplicated.
- Same-address conflict: CPU writes 0x30=0xAAAA0000 and DMA writes 0x30=0x0000BBBB, counter at limit:
  - DMA wins, RAM=0x0000BBBB.
  - Next cycle the CPU write lands, RAM=0xAAAA0000.
- rst_n pulsed low while dma_req pending with counter=3 → counter 0, dma_rvalid 0 immediately. After release, 4 further denied cycles are required before the forced grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage
// and a DMA/loader port; CPU has priority, starvation forces a DMA slot.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic              owner_q, owner_d;
  logic              force_gnt;
  logic              cpu_gnt;

  // Grant decision: CPU wins unless the DMA has waited STARVE_LIMIT cycles
  always_comb begin
    force_gnt = dma_req && (starve_cnt_q == LIMIT);
    dma_gnt   = dma_req && (!cpu_req || force_gnt);
    cpu_gnt   = cpu_req && !dma_gnt;
    cpu_stall = cpu_req && dma_gnt;
  end

  // RAM port mux; idle cycles drive all-zero to the RAM
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_rdata = '0;
    unique case (1'b1)
      dma_gnt: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_read  = !dma_we;
        mem_write = dma_we;
      end
      cpu_gnt: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = !cpu_we;
        mem_write = cpu_we;
        cpu_rdata = cpu_we ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

  // Next-state: starvation count, DMA read capture, last owner
  always_comb begin
    starve_cnt_d = '0;
    if (dma_req && !dma_gnt) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                             : starve_cnt_q + 1'b1;
    end
    dma_rvalid_d = dma_gnt && !dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    owner_d      = owner_q;
    if (dma_gnt) begin
      owner_d = OWN_DMA;
    end else if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end
  end

  // State registers; reset aborts any in-flight DMA return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
      owner_q      <= OWN_CPU;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
      owner_q      <= owner_d;
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus, behavioural reference with shadow RAM,
// per-cycle compare plus literal expectations.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int checks = 0;
  int errors = 0;
  int w50 = 0;

  logic [31:0] ram [0:255];
  logic [31:0] sh  [0:255];
  int          m_wait;
  logic        m_rv;
  logic [31:0] m_rd;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // environment RAM: combinational read, posedge write
  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
    if (mem_write && mem_addr == 32'h50) w50 <= w50 + 1;
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // reference: who may use the RAM this cycle
  function automatic logic m_dgnt();
    return dma_req && (!cpu_req || m_wait == LIM);
  endfunction

  // reference state: DMA waiting time, shadow memory, read return
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0;
      m_rv   <= 1'b0;
      m_rd   <= 32'h0;
    end else begin
      logic g;
      g = m_dgnt();
      if (dma_req && !g) m_wait <= (m_wait < LIM) ? m_wait + 1 : LIM;
      else m_wait <= 0;
      m_rv <= g && !dma_we;
      if (g && !dma_we) m_rd <= sh[dma_addr[9:2]];
      if (g && dma_we) sh[dma_addr[9:2]] <= dma_wdata;
      else if (!g && cpu_req && cpu_we) sh[cpu_addr[9:2]] <= cpu_wdata;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    logic dg, cg;
    logic [31:0] ea, ew, er;
    dg = m_dgnt();
    cg = cpu_req && !dg;
    ea = dg ? dma_addr : (cg ? cpu_addr : 32'h0);
    ew = dg ? dma_wdata : (cg ? cpu_wdata : 32'h0);
    er = (cg && !cpu_we) ? sh[cpu_addr[9:2]] : 32'h0;
    chk("dma_gnt", 32'(dma_gnt), 32'(dg));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && dg));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_read", 32'(mem_read),
        32'((dg && !dma_we) || (cg && !cpu_we)));
    chk("mem_write", 32'(mem_write),
        32'((dg && dma_we) || (cg && cpu_we)));
    chk("cpu_rdata", cpu_rdata, er);
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rv));
    chk("dma_rdata", dma_rdata, m_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h0;
      sh[i]  = 32'h0;
    end
    ram[8'h08] = 32'h12345678;
    sh[8'h08]  = 32'h12345678;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    #23 rst_n = 1'b1;
    step();

    // idle after reset
    at_neg();
    chk("idle_mem_rw", 32'({mem_read, mem_write}), 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_rv", 32'({dma_rvalid, dma_gnt, cpu_stall}), 0);
    chk("idle_rdata", dma_rdata, 0);
    step();

    // CPU write then read 0x10
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    at_neg();
    chk("cpu_wr", 32'({mem_write, cpu_stall}), 32'h2);
    step();
    cpu_we = 0; cpu_wdata = 0;
    at_neg();
    chk("cpu_rd", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_stall", 32'(cpu_stall), 0);
    step();
    cpu_req = 0; cpu_addr = 0;

    // DMA-only read of 0x20
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    at_neg();
    chk("dma_gnt_now", 32'(dma_gnt), 1);
    step();
    dma_req = 0; dma_addr = 0;
    at_neg();
    chk("dma_rv1", 32'(dma_rvalid), 1);
    chk("dma_rd1", dma_rdata, 32'h12345678);
    step();
    at_neg();
    chk("dma_rv_once", 32'(dma_rvalid), 0);
    step();

    // starvation with continuous CPU traffic
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("starve_deny", 32'(dma_gnt), 0);
      step();
      if (i == 3) begin
        cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h55;
      end
    end
    at_neg();
    chk("starve_force", 32'({dma_gnt, cpu_stall}), 32'h3);
    step();
    dma_req = 0; dma_addr = 0;
    at_neg();
    chk("cpu_after_force", 32'({mem_write, cpu_stall}), 32'h2);
    chk("force_rv", 32'(dma_rvalid), 1);
    step();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    at_neg();
    chk("no_dup_write", 32'(w50), 1);
    step();

    // same-address conflict at the limit
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'h0000BBBB;
    repeat (4) step();
    cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA0000;
    at_neg();
    chk("conf_dma_wins", 32'(dma_gnt), 1);
    step();
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    at_neg();
    chk("conf_ram_dma", ram[8'h0C], 32'h0000BBBB);
    step();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    at_neg();
    chk("conf_ram_cpu", ram[8'h0C], 32'hAAAA0000);
    step();

    // reset while DMA starved with count 3
    cpu_req = 1; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rst_rv", 32'(dma_rvalid), 0);
    chk("rst_gnt", 32'(dma_gnt), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("post_rst_deny", 32'(dma_gnt), 0);
      step();
    end
    at_neg();
    chk("post_rst_force", 32'(dma_gnt), 1);
    step();
    cpu_req = 0; dma_req = 0; cpu_addr = 0; dma_addr = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
